// File: rtl/blur_kernel_sequencer.sv
`timescale 1ns/1ps
// blur_kernel_sequencer
//   Sequences one 3x3 Gaussian blur pass over an image held in a frame BRAM.
//   For every centre pixel, in raster order, nine neighbourhood reads are
//   issued with edge saturation. The returned pixels are packed into three
//   row words for the blur unit. The design then waits for the blurred pixel,
//   writes it to the destination region and moves to the next pixel.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   start_in                begin a pass (IDLE only); geometry/bases latched
//   img_width_in/height_in  active image size, 1..WIDTH / 1..HEIGHT
//   src_base_in/dst_base_in source / destination base addresses
//   rd_addr_out/rd_en_out   source BRAM read port; rd_data_in returns
//                           RD_LATENCY cycles after rd_en_out
//   r0/r1/r2_data_out       kernel rows {right,centre,left}, top to bottom
//   kernel_valid_out        one-cycle strobe to the blur unit
//   blur_data_in/valid_in   blurred pixel from the blur unit
//   wr_addr/data/en_out     destination write port, one strobe per pixel
//   busy_out, done_out      pass active / one-cycle pass-complete pulse
//   error_out               sticky: bad geometry or stray blur_valid_in
module blur_kernel_sequencer #(
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned HEIGHT     = 128,
  parameter int unsigned BIT_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [7:0]               img_width_in,
  input  logic [7:0]               img_height_in,
  input  logic [ADDR_WIDTH-1:0]    src_base_in,
  input  logic [ADDR_WIDTH-1:0]    dst_base_in,
  output logic [ADDR_WIDTH-1:0]    rd_addr_out,
  output logic                     rd_en_out,
  input  logic [BIT_DEPTH-1:0]     rd_data_in,
  output logic [3*BIT_DEPTH-1:0]   r0_data_out,
  output logic [3*BIT_DEPTH-1:0]   r1_data_out,
  output logic [3*BIT_DEPTH-1:0]   r2_data_out,
  output logic                     kernel_valid_out,
  input  logic [BIT_DEPTH-1:0]     blur_data_in,
  input  logic                     blur_valid_in,
  output logic [ADDR_WIDTH-1:0]    wr_addr_out,
  output logic [BIT_DEPTH-1:0]     wr_data_out,
  output logic                     wr_en_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out
);

  localparam int unsigned LAST = RD_LATENCY - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ISSUE,
    S_WAIT_BLUR,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                                state_q, state_d;
  logic [7:0]                            w_q, w_d, h_q, h_d;
  logic [ADDR_WIDTH-1:0]                 src_q, src_d, dst_q, dst_d;
  logic [7:0]                            cx_q, cx_d, cy_q, cy_d;
  logic [1:0]                            kx_q, kx_d, ky_q, ky_d;
  logic [RD_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0][1:0]            pipe_kx_q, pipe_kx_d;
  logic [RD_LATENCY-1:0][1:0]            pipe_ky_q, pipe_ky_d;
  logic [2:0][2:0][BIT_DEPTH-1:0]        row_q, row_d;
  logic                                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]                 rd_addr_q, rd_addr_d;
  logic                                  kernel_valid_q, kernel_valid_d;
  logic                                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]                 wr_addr_q, wr_addr_d;
  logic [BIT_DEPTH-1:0]                  wr_data_q, wr_data_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic                                  err_q, err_d;
  logic                                  start_ok;

  // Neighbour coordinate: off 0/1/2 selects c-1/c/c+1, saturated to [0, lim-1].
  function automatic logic [7:0] nbr(input logic [7:0] c, input logic [1:0] off,
                                     input logic [7:0] lim);
    logic [7:0] r;
    r = c;
    if (off == 2'd0 && c != 8'd0)
      r = c - 8'd1;
    else if (off == 2'd2 && c != lim - 8'd1)
      r = c + 8'd1;
    return r;
  endfunction

  // Linear address base + y*w + x, truncated to the BRAM address width.
  function automatic logic [ADDR_WIDTH-1:0] lin(input logic [ADDR_WIDTH-1:0] base,
                                                input logic [7:0] x, input logic [7:0] y,
                                                input logic [7:0] w);
    logic [15:0] p;
    p = y * w;
    return base + ADDR_WIDTH'(p) + ADDR_WIDTH'(x);
  endfunction

  assign start_ok = (img_width_in != 8'd0) && (img_height_in != 8'd0) &&
                    (32'(img_width_in) <= WIDTH) && (32'(img_height_in) <= HEIGHT);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    kx_d      = kx_q;
    ky_d      = ky_q;
    row_d     = row_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    // Read-return tracker: each slot carries the kernel index of an
    // outstanding read so the data lands in the right row/slot.
    pipe_vld_d[0] = rd_en_q;
    pipe_kx_d[0]  = kx_q;
    pipe_ky_d[0]  = ky_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_kx_d[i]  = pipe_kx_q[i-1];
      pipe_ky_d[i]  = pipe_ky_q[i-1];
    end
    if (pipe_vld_q[LAST])
      row_d[pipe_ky_q[LAST]][pipe_kx_q[LAST]] = rd_data_in;

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (start_ok) begin
            w_d     = img_width_in;
            h_d     = img_height_in;
            src_d   = src_base_in;
            dst_d   = dst_base_in;
            cx_d    = '0;
            cy_d    = '0;
            kx_d    = '0;
            ky_d    = '0;
            err_d   = 1'b0;
            state_d = S_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (kx_q == 2'd2) begin
          kx_d = '0;
          if (ky_q == 2'd2) begin
            ky_d    = '0;
            state_d = S_DRAIN;
          end else begin
            ky_d = ky_q + 2'd1;
          end
        end else begin
          kx_d = kx_q + 2'd1;
        end
      end
      S_DRAIN: begin
        // Leave once the return for index 8 is being captured this cycle.
        if (pipe_vld_q[LAST] && pipe_kx_q[LAST] == 2'd2 && pipe_ky_q[LAST] == 2'd2)
          state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_BLUR;
      S_WAIT_BLUR: begin
        if (blur_valid_in) begin
          wr_data_d = blur_data_in;
          wr_addr_d = lin(dst_q, cx_q, cy_q, w_q);
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cx_q == w_q - 8'd1) begin
          cx_d = '0;
          if (cy_q == h_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            cy_d    = cy_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          cx_d    = cx_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Evaluated last so a stray result pulse is never masked by a start.
    if (blur_valid_in && state_q != S_WAIT_BLUR)
      err_d = 1'b1;

    // Outputs are registered from the next-state values so they line up
    // with the state they belong to.
    rd_en_d        = (state_d == S_FETCH);
    rd_addr_d      = rd_en_d ? lin(src_d, nbr(cx_d, kx_d, w_d), nbr(cy_d, ky_d, h_d), w_d)
                             : '0;
    kernel_valid_d = (state_d == S_ISSUE);
    wr_en_d        = (state_d == S_WRITE);
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= S_IDLE;
      w_q            <= '0;
      h_q            <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      kx_q           <= '0;
      ky_q           <= '0;
      pipe_vld_q     <= '0;
      pipe_kx_q      <= '0;
      pipe_ky_q      <= '0;
      row_q          <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      kernel_valid_q <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      w_q            <= w_d;
      h_q            <= h_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      kx_q           <= kx_d;
      ky_q           <= ky_d;
      pipe_vld_q     <= pipe_vld_d;
      pipe_kx_q      <= pipe_kx_d;
      pipe_ky_q      <= pipe_ky_d;
      row_q          <= row_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      kernel_valid_q <= kernel_valid_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign rd_addr_out      = rd_addr_q;
  assign rd_en_out        = rd_en_q;
  assign r0_data_out      = row_q[0];
  assign r1_data_out      = row_q[1];
  assign r2_data_out      = row_q[2];
  assign kernel_valid_out = kernel_valid_q;
  assign wr_addr_out      = wr_addr_q;
  assign wr_data_out      = wr_data_q;
  assign wr_en_out        = wr_en_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign error_out        = err_q;

endmodule

// File: tb/tb_blur_kernel_sequencer.sv
`timescale 1ns/1ps
// Testbench for blur_kernel_sequencer: BRAM and blur-unit models plus a
// reference that derives reads, kernels and writes from the source image.
module tb_blur_kernel_sequencer;

  localparam int unsigned AW   = 15;
  localparam int          MASK = 32'h7FFF;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic [7:0]    img_width_in, img_height_in;
  logic [AW-1:0] src_base_in, dst_base_in;
  logic [AW-1:0] rd_addr_out;
  logic          rd_en_out;
  logic [7:0]    rd_data_in;
  logic [23:0]   r0_data_out, r1_data_out, r2_data_out;
  logic          kernel_valid_out;
  logic [7:0]    blur_data_in;
  logic          blur_valid_in;
  logic [AW-1:0] wr_addr_out;
  logic [7:0]    wr_data_out;
  logic          wr_en_out, busy_out, done_out, error_out;

  blur_kernel_sequencer #(
    .WIDTH(128), .HEIGHT(128), .BIT_DEPTH(8), .ADDR_WIDTH(AW), .RD_LATENCY(2)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .img_width_in(img_width_in), .img_height_in(img_height_in),
    .src_base_in(src_base_in), .dst_base_in(dst_base_in),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out), .rd_data_in(rd_data_in),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r2_data_out(r2_data_out),
    .kernel_valid_out(kernel_valid_out), .blur_data_in(blur_data_in),
    .blur_valid_in(blur_valid_in), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out), .wr_en_out(wr_en_out), .busy_out(busy_out),
    .done_out(done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] mem [0:32767];
  int n_checks = 0, n_fail = 0;
  int w = 1, h = 1, src = 0, dst = 0, mode = 0, blur_lat = 4;
  int n_reads = 0, n_kern = 0, n_writes = 0, n_done = 0;
  int cyc = 0, rd0_cyc = 0;
  bit spur_req = 1'b0;
  logic [23:0] first_r0, first_r1, first_r2, last_r2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(int v, int lim);
    return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
  endfunction

  function automatic int pix_addr(int x, int y);
    return (src + clampi(y, h) * w + clampi(x, w)) & MASK;
  endfunction

  function automatic int pix(int x, int y);
    return int'(mem[pix_addr(x, y)]);
  endfunction

  function automatic logic [7:0] gauss9(int a, int b, int c, int d, int e, int f,
                                        int g, int hh, int i);
    int s;
    s = a + 2*b + c + 2*d + 4*e + 2*f + g + 2*hh + i;
    return 8'(s >> 4);
  endfunction

  function automatic logic [23:0] ref_row(int p, int ky);
    int cx, cy;
    cx = p % w;
    cy = p / w;
    return {8'(pix(cx + 1, cy + ky - 1)), 8'(pix(cx, cy + ky - 1)), 8'(pix(cx - 1, cy + ky - 1))};
  endfunction

  function automatic logic [7:0] ref_out(int p);
    int cx, cy;
    cx = p % w;
    cy = p / w;
    if (mode == 0) return 8'(pix(cx, cy));
    return gauss9(pix(cx-1,cy-1), pix(cx,cy-1), pix(cx+1,cy-1),
                  pix(cx-1,cy),   pix(cx,cy),   pix(cx+1,cy),
                  pix(cx-1,cy+1), pix(cx,cy+1), pix(cx+1,cy+1));
  endfunction

  function automatic int exp_rd(int n);
    int p, k;
    p = n / 9;
    k = n % 9;
    return pix_addr(p % w + k % 3 - 1, p / w + k / 3 - 1);
  endfunction

  // Source BRAM: two-cycle read latency.
  initial begin : bram
    logic [AW-1:0] q0, q1;
    q0 = '0;
    q1 = '0;
    rd_data_in = '0;
    forever begin
      @(negedge clk_in);
      rd_data_in = mem[q1];
      q1 = q0;
      if (rd_en_out) q0 = rd_addr_out;
    end
  end

  // Blur unit: answers blur_lat cycles after each kernel strobe.
  initial begin : blur_unit
    int cd;
    logic [7:0] res;
    cd = 0;
    res = '0;
    blur_valid_in = 1'b0;
    blur_data_in = '0;
    forever begin
      @(negedge clk_in);
      blur_valid_in = 1'b0;
      if (!rst_in) begin
        cd = 0;
        continue;
      end
      if (spur_req) begin
        blur_valid_in = 1'b1;
        spur_req = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          blur_valid_in = 1'b1;
          blur_data_in = res;
        end
      end
      if (kernel_valid_out) begin
        if (mode == 0) res = r1_data_out[15:8];
        else res = gauss9(r0_data_out[7:0], r0_data_out[15:8], r0_data_out[23:16],
                          r1_data_out[7:0], r1_data_out[15:8], r1_data_out[23:16],
                          r2_data_out[7:0], r2_data_out[15:8], r2_data_out[23:16]);
        cd = blur_lat;
      end
    end
  end

  // Monitor: every read, kernel and write is checked against the reference.
  initial begin : monitor
    forever begin
      @(negedge clk_in);
      cyc++;
      if (!rst_in) continue;
      if (rd_en_out) begin
        if (n_reads % 9 == 0) rd0_cyc = cyc;
        check("rd_addr", 32'(rd_addr_out), exp_rd(n_reads));
        n_reads++;
      end
      if (kernel_valid_out) begin
        check("kern_r0", 32'(r0_data_out), 32'(ref_row(n_kern, 0)));
        check("kern_r1", 32'(r1_data_out), 32'(ref_row(n_kern, 1)));
        check("kern_r2", 32'(r2_data_out), 32'(ref_row(n_kern, 2)));
        check("kern_latency", cyc - rd0_cyc, 11);
        if (n_kern == 0) begin
          first_r0 = r0_data_out;
          first_r1 = r1_data_out;
          first_r2 = r2_data_out;
        end
        last_r2 = r2_data_out;
        n_kern++;
      end
      if (wr_en_out) begin
        check("wr_addr", 32'(wr_addr_out), (dst + n_writes) & MASK);
        check("wr_data", 32'(wr_data_out), 32'(ref_out(n_writes)));
        n_writes++;
      end
      if (done_out) n_done++;
    end
  end

  task automatic setup(input int pw, input int ph, input int ps, input int pd,
                       input int pm, input int pl);
    w = pw; h = ph; src = ps; dst = pd; mode = pm; blur_lat = pl;
    n_reads = 0; n_kern = 0; n_writes = 0; n_done = 0;
  endtask

  task automatic pulse_start(input int pw, input int ph, input int ps, input int pd);
    @(negedge clk_in);
    start_in = 1'b1;
    img_width_in = 8'(pw);
    img_height_in = 8'(ph);
    src_base_in = AW'(ps);
    dst_base_in = AW'(pd);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic run_pass(input int pw, input int ph, input int ps, input int pd,
                          input int pm, input int pl, input bit spur);
    int limit;
    setup(pw, ph, ps, pd, pm, pl);
    pulse_start(pw, ph, ps, pd);
    check("err_clear_on_start", 32'(error_out), 0);
    if (spur) begin
      // Stray result plus an ignored start, both during the first FETCH.
      for (int i = 0; i < 20 && !rd_en_out; i++) @(negedge clk_in);
      spur_req = 1'b1;
      start_in = 1'b1;
      img_width_in = 8'd2;
      img_height_in = 8'd2;
      src_base_in = AW'(ps + 7);
      dst_base_in = AW'(pd + 7);
      @(negedge clk_in);
      start_in = 1'b0;
    end
    limit = pw * ph * (20 + pl) + 100;
    for (int i = 0; i < limit && n_done == 0; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    check("done_count", n_done, 1);
    check("write_count", n_writes, pw * ph);
    check("read_count", n_reads, 9 * pw * ph);
    check("busy_after", 32'(busy_out), 0);
    check("err_after", 32'(error_out), spur ? 1 : 0);
  endtask

  task automatic bad_start(input int pw, input int ph);
    int r0;
    setup(4, 4, 0, 0, 0, 4);
    r0 = n_reads;
    pulse_start(pw, ph, 0, 0);
    check("bad_start_err", 32'(error_out), 1);
    check("bad_start_busy", 32'(busy_out), 0);
    repeat (5) @(negedge clk_in);
    check("bad_start_reads", n_reads, r0);
    check("bad_start_idle", 32'(busy_out), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy_out), 0);
    check({tag, "_rd_en"}, 32'(rd_en_out), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr_out), 0);
    check({tag, "_wr_en"}, 32'(wr_en_out), 0);
    check({tag, "_wr_data"}, 32'(wr_data_out), 0);
    check({tag, "_kv"}, 32'(kernel_valid_out), 0);
    check({tag, "_done"}, 32'(done_out), 0);
    check({tag, "_err"}, 32'(error_out), 0);
    check({tag, "_rows"}, 32'({r0_data_out, r1_data_out} == '0 && r2_data_out == '0), 1);
  endtask

  initial begin : main
    int wrs, rw, rh, rs, rd;
    start_in = 1'b0;
    img_width_in = '0;
    img_height_in = '0;
    src_base_in = '0;
    dst_base_in = '0;
    rst_in = 1'b1;
    for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
    #1 rst_in = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(negedge clk_in);
    check_all_zero("reset_hold");
    rst_in = 1'b1;

    // 4x4 ramp image, centre-value blur, destination 0x100.
    run_pass(4, 4, 0, 32'h100, 0, 4, 1'b0);
    check("first_r0", 32'(first_r0), 32'h010000);
    check("first_r1", 32'(first_r1), 32'h010000);
    check("first_r2", 32'(first_r2), 32'h050404);
    check("last_r2", 32'(last_r2), 32'h0F0F0E);

    bad_start(0, 4);
    bad_start(4, 200);
    bad_start(129, 4);
    run_pass(3, 5, 32'h40, 32'h300, 1, 2, 1'b0);

    // Stray blur_valid_in during FETCH; pass must still write correct data.
    run_pass(5, 3, 32'h200, 32'h500, 1, 3, 1'b1);

    // Reset while waiting on the blur result of pixel 5.
    setup(4, 4, 0, 32'h100, 0, 8);
    pulse_start(4, 4, 0, 32'h100);
    for (int i = 0; i < 400 && n_kern < 6; i++) @(negedge clk_in);
    check("reached_pixel5", n_kern, 6);
    #2 rst_in = 1'b0;
    #1 check_all_zero("midpass_reset");
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    wrs = n_writes;
    repeat (20) @(negedge clk_in);
    check("no_write_after_reset", n_writes, wrs);
    check("idle_after_reset", 32'(busy_out), 0);
    run_pass(4, 4, 0, 32'h100, 0, 4, 1'b0);

    // Edge geometries and randomized passes with a Gaussian blur model.
    mem[32'h1234] = 8'h5A;
    run_pass(1, 1, 32'h1234, 32'h10, 1, 1, 1'b0);
    for (int i = 0; i < 128; i++) mem[(32'h7FC0 + i) & MASK] = 8'($urandom);
    run_pass(128, 1, 32'h7FC0, 32'h2000, 1, 2, 1'b0);
    run_pass(1, 6, 32'h900, 32'h1000, 1, 3, 1'b0);
    for (int t = 0; t < 6; t++) begin
      rw = int'($urandom_range(1, 12));
      rh = int'($urandom_range(1, 12));
      rs = int'($urandom_range(0, 32767));
      rd = int'($urandom_range(0, 32767));
      for (int i = 0; i < rw * rh; i++) mem[(rs + i) & MASK] = 8'($urandom);
      run_pass(rw, rh, rs, rd, 1, int'($urandom_range(1, 5)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
